// File: rtl/mul_32.sv
// Signed 32x32 radix-4 Booth multiplier producing a 64-bit product in hi/lo.
// Latency: start sampled at E0, product written and done pulsed at E16 (17-cycle issue rate).
// No backpressure: start is ignored while busy; accepted in IDLE or in the DONE cycle.
module mul_32 (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state;
   logic [33:0] a;      // partial-product accumulator
   logic [32:0] q;      // multiplier with appended Booth guard bit
   logic [33:0] m;      // sign-extended multiplicand
   logic [3:0]  cnt;    // Booth digit index

   logic [33:0] addend;
   logic [33:0] sum;
   logic [33:0] a_nx;
   logic [32:0] q_nx;

   // Booth digit select, accumulate, then arithmetic shift {A,Q} right by two
   always_comb begin
      addend = '0;
      case (q[2:0])
         3'b001, 3'b010: addend = m;
         3'b011:         addend = {m[32:0], 1'b0};
         3'b100:         addend = -{m[32:0], 1'b0};
         3'b101, 3'b110: addend = -m;
         default:        addend = '0;
      endcase
      sum  = a + addend;
      a_nx = {sum[33], sum[33], sum[33:2]};
      q_nx = {sum[1:0], q[32:2]};
   end

   // Control FSM and datapath registers; clr overrides every transition
   always_ff @(posedge clk) begin
      if (clr) begin
         state <= S_IDLE;
         a     <= '0;
         q     <= '0;
         m     <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  m     <= {{2{multiplicand[31]}}, multiplicand};
                  q     <= {multiplier, 1'b0};
                  a     <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               a   <= a_nx;
               q   <= q_nx;
               cnt <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  // last digit: product is the shifted {A,Q} minus the guard bit
                  hi    <= a_nx[31:0];
                  lo    <= q_nx[32:1];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  // back-to-back issue straight from the completion cycle
                  m     <= {{2{multiplicand[31]}}, multiplicand};
                  q     <= {multiplier, 1'b0};
                  a     <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mul_32.md
# mul_32

Sequential signed 32×32 multiplier for the CPU datapath. It produces the 64-bit product in the HI/LO pair using radix-4 Booth recoding, one recoded digit per clock, so a multiply takes 16 cycles. It is the multiply counterpart of the ALU's division unit. The control unit starts it with a one-cycle `start` pulse and waits for `done` before moving HI/LO onto the bus.

## Interface
- No parameters; widths are fixed at 32-bit operands and a 64-bit product.
- `clk  input  1  system clock; all state changes on the rising edge`
- `clr  input  1  reset; synchronous, active-high`
- `start  input  1  request a multiply; sampled on the rising edge`
- `multiplicand  input  32  signed operand M (two's complement); sampled when start is accepted`
- `multiplier  input  32  signed operand Q (two's complement); sampled when start is accepted`
- `busy  output  1  high while a multiply is in progress (RUN state)`
- `done  output  1  one-cycle pulse; result valid`
- `hi  output  32  product[63:32]`
- `lo  output  32  product[31:0]`

## Operation
- States: IDLE, RUN, DONE.
- `start` is accepted only in IDLE or DONE. It is ignored in RUN.
- On accept:
  - latch M, sign-extended to 34 bits;
  - load a 33-bit Q register with {multiplier, 1'b0};
  - clear the 34-bit accumulator A;
  - set the step counter to 0;
  - go to RUN.
- Each RUN cycle, Q[2:0] selects the addend:
  - 000 and 111: 0
  - 001 and 010: +M
  - 011: +2M
  - 100: −2M
  - 101 and 110: −M
- After the add, {A,Q} (67 bits) is arithmetic-shifted right by 2, with the sign taken from A[33].
- The step counter increments each RUN cycle. After step 15 (16 steps total):
  - {hi,lo} is loaded with {A[31:0], Q[32:1]};
  - the state goes to DONE.
- DONE lasts one cycle, with `done`=1. It then returns to IDLE, unless `start` is sampled high in DONE, in which case it goes straight to RUN.
- `hi`/`lo` are separate output registers. They hold the previous result throughout RUN and change only on the completion edge. They hold their value indefinitely in IDLE.
- Full signed range is supported. The product of two 32-bit signed values always fits in 64 bits, so there is no overflow flag.
- Operand inputs may change freely after the accept edge; the block uses only the latched values.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0, A/Q/M cleared.
- `clr` has priority over `start` and over every state transition.
- `clr` asserted mid-RUN aborts the multiply: `done` is never pulsed for that operation, and `hi`/`lo` read 0 on the cycle after the reset edge.
- Latency:
  - edge E0 samples `start`=1 in IDLE;
  - `busy`=1 after E0 through E16;
  - the product is written at E16;
  - `done`=1 for exactly the cycle between E16 and E17;
  - `busy`=0 during DONE.
- Throughput: with `start` held high, a new multiply is accepted in every DONE cycle, giving one result per 17 cycles.
- `busy` and `done` are never high together.

## Test plan
- 7 × 6, `start` pulsed → `done` 16 edges after the start edge; `hi`=0x00000000, `lo`=0x0000002A.
- −1 × −1 (0xFFFFFFFF × 0xFFFFFFFF) → `hi`=0x00000000, `lo`=0x00000001.
- 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000. In the same run, 0x7FFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFF, `lo`=0x80000001.
- Start 5 × 3, then pulse `start` with 9 × 9 at step 8 → that start is ignored. `done` arrives at the original time with `lo`=15, and `hi`/`lo` keep the previous result until then.
- Hold `start` high with 2 × 3, then 4 × 5 → `done` pulses 17 cycles apart; `lo`=6, then `lo`=20; `busy` is low only in the DONE cycles.
- Assert `clr` at step 10 of 0x12345678 × 0x9ABCDEF0 → no `done`; the cycle after reset shows `busy`=0, `hi`=`lo`=0. A following 3 × −4 then gives `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF4.
